dma_write_master: RTL and testbench

DMA_WRITE_MASTER -- requirements
Module: dma_write_master

---
 rtl/dma_write_master.sv | 89 ++++++++
 tb/tb_dma_write_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_write_master.sv
// Avalon-MM write master: drains a show-ahead FIFO into consecutive word
// addresses starting at a latched destination, one word per accepted beat.
module dma_write_master #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iDst_addr,
  input  logic [LEN_W-1:0]  iLength,
  output logic              oBusy,
  output logic              oDone,
  input  logic [31:0]       FF_q,
  input  logic              FF_empty,
  output logic              FF_readrequest,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-3:0] remaining_q, remaining_d;
  logic             beat_accepted;

  // Byte offsets of address and length are dropped by design.
  logic unused_low_bits;
  assign unused_low_bits = ^{iDst_addr[1:0], iLength[1:0]};

  assign avm_write      = (state_q == ST_WRITE) && !FF_empty;
  assign beat_accepted  = avm_write && !avm_waitrequest;
  assign FF_readrequest = beat_accepted;
  assign avm_address    = addr_q;
  assign avm_writedata  = FF_q;
  assign avm_byteenable = 4'b1111;
  assign oBusy          = (state_q == ST_WRITE) || (state_q == ST_DONE);
  assign oDone          = (state_q == ST_DONE);

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          addr_d      = {iDst_addr[ADDR_W-1:2], 2'b00};
          remaining_d = iLength[LEN_W-1:2];
          state_d     = (iLength[LEN_W-1:2] == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (beat_accepted) begin
          addr_d = addr_q + ADDR_W'(4);
          // Counter is only decremented while non-zero so it cannot wrap.
          if (remaining_q != '0) begin
            remaining_d = remaining_q - (LEN_W-2)'(1);
          end
          if (remaining_q <= (LEN_W-2)'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: tb/tb_dma_write_master.sv
// Randomized bench for dma_write_master: a queue-based FIFO and a beat
// scoreboard predict every address, data word and status flag per cycle.
module tb_dma_write_master;

  logic        iClk = 1'b0;
  logic        iReset, iStart;
  logic [31:0] iDst_addr, iLength;
  logic        oBusy, oDone;
  logic [31:0] FF_q;
  logic        FF_empty, FF_readrequest;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_write, avm_waitrequest;
  logic [3:0]  avm_byteenable;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] fifo[$];
  logic [31:0] exp_data[$];

  always #5 iClk = ~iClk;

  dma_write_master #(.ADDR_W(32), .LEN_W(32)) dut (
    .iClk(iClk), .iReset(iReset), .iStart(iStart), .iDst_addr(iDst_addr),
    .iLength(iLength), .oBusy(oBusy), .oDone(oDone), .FF_q(FF_q),
    .FF_empty(FF_empty), .FF_readrequest(FF_readrequest),
    .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    FF_empty = (fifo.size() == 0);
    FF_q     = FF_empty ? 32'hDEAD_BEEF : fifo[0];
  endtask

  task automatic push_word(input logic [31:0] v);
    fifo.push_back(v);
    exp_data.push_back(v);
  endtask

  task automatic flush();
    fifo.delete();
    exp_data.delete();
  endtask

  // Caller must be just past a falling edge with the DUT idle; iStart is
  // raised immediately so it is taken on the very next rising edge.
  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] len,
                          input int prefill, input int push_period,
                          input int stall_pct, input int stall_beat,
                          input int stall_len, input int restart_cycle,
                          output int write_cycles);
    int          words;
    logic [31:0] exp_addr;
    int          beats;
    int          cyc;
    int          stall_cnt;
    bit          pop_pending;
    bit          done_seen;
    bit          finished;
    words        = int'(len >> 2);
    exp_addr     = {addr[31:2], 2'b00};
    beats        = 0;
    cyc          = 0;
    stall_cnt    = 0;
    pop_pending  = 0;
    done_seen    = 0;
    finished     = 0;
    write_cycles = 0;
    flush();
    for (int i = 0; i < prefill; i++) push_word($urandom);
    drive_fifo();
    avm_waitrequest = 1'b0;
    iDst_addr = addr;
    iLength   = len;
    iStart    = 1'b1;
    #1;
    check("pre_busy", oBusy, 1'b0);
    check("pre_write", avm_write, 1'b0);
    while (!finished && cyc < 3000) begin
      @(negedge iClk);
      cyc++;
      iStart = (cyc == restart_cycle);
      if (iStart) begin
        iDst_addr = $urandom;
        iLength   = 32'h40;
      end
      if (pop_pending) begin
        void'(fifo.pop_front());
        pop_pending = 0;
      end
      if (push_period > 0 && (cyc % push_period) == 0) push_word($urandom);
      if (beats == stall_beat && stall_cnt < stall_len && fifo.size() != 0) begin
        avm_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        avm_waitrequest = ($urandom_range(0, 99) < stall_pct);
      end
      drive_fifo();
      #1;
      if (beats < words) begin
        write_cycles++;
        check("busy", oBusy, 1'b1);
        check("done_low", oDone, 1'b0);
        check("write", avm_write, !FF_empty);
        check("byteen", avm_byteenable, 4'hF);
        if (!FF_empty) begin
          check("addr", avm_address, exp_addr);
          check("wdata", avm_writedata, fifo[0]);
          check("pop", FF_readrequest, !avm_waitrequest);
          if (!avm_waitrequest) begin
            check("beat_data", avm_writedata, exp_data.pop_front());
            beats++;
            exp_addr += 32'd4;
            pop_pending = 1;
          end
        end else begin
          check("pop_empty", FF_readrequest, 1'b0);
        end
      end else if (!done_seen) begin
        check("done", oDone, 1'b1);
        check("done_busy", oBusy, 1'b1);
        check("done_write", avm_write, 1'b0);
        check("done_pop", FF_readrequest, 1'b0);
        done_seen = 1;
      end else begin
        check("end_busy", oBusy, 1'b0);
        check("end_done", oDone, 1'b0);
        check("end_write", avm_write, 1'b0);
        finished = 1;
      end
    end
    if (!finished) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: beats %0d of %0d after %0d cycles", beats, words, cyc);
    end
    iStart = 1'b0;
    avm_waitrequest = 1'b0;
  endtask

  int wc;

  initial begin
    iReset = 1'b1;
    iStart = 1'b0;
    iDst_addr = '0;
    iLength = '0;
    avm_waitrequest = 1'b0;
    flush();
    drive_fifo();
    #1;
    check("rst_busy", oBusy, 1'b0);
    check("rst_done", oDone, 1'b0);
    check("rst_write", avm_write, 1'b0);
    check("rst_pop", FF_readrequest, 1'b0);
    check("rst_addr", avm_address, 32'h0);
    @(negedge iClk);
    @(negedge iClk);
    iReset = 1'b0;

    // Basic four-word transfer, started on the first edge after reset.
    run_xfer(32'h1000, 32'd16, 4, 0, 0, -1, 0, 0, wc);
    check("basic_cycles", wc, 32'd4);

    // Three-cycle stall on the second beat.
    run_xfer(32'h1000, 32'd16, 4, 0, 0, 1, 3, 0, wc);
    check("stall_cycles", wc, 32'd7);

    // Starved FIFO: one word every five cycles.
    run_xfer(32'h3000, 32'd16, 0, 5, 0, -1, 0, 0, wc);
    check("starve_cycles", wc, 32'd20);

    // Zero and odd lengths.
    run_xfer(32'h4000, 32'd0, 2, 0, 0, -1, 0, 0, wc);
    check("zero_cycles", wc, 32'd0);
    run_xfer(32'h5003, 32'd7, 3, 0, 0, -1, 0, 0, wc);
    check("odd_cycles", wc, 32'd1);

    // Address wrap with a second start issued mid-transfer.
    run_xfer(32'hFFFF_FFF8, 32'd16, 4, 0, 0, -1, 0, 2, wc);
    check("wrap_cycles", wc, 32'd4);

    // Reset while the second of four beats is on the bus.
    flush();
    for (int i = 0; i < 4; i++) push_word($urandom);
    drive_fifo();
    iDst_addr = 32'h2000;
    iLength   = 32'd16;
    iStart    = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    #1;
    check("mid_beat1_addr", avm_address, 32'h2000);
    check("mid_beat1_write", avm_write, 1'b1);
    @(negedge iClk);
    void'(fifo.pop_front());
    drive_fifo();
    #1;
    check("mid_beat2_addr", avm_address, 32'h2004);
    check("mid_beat2_write", avm_write, 1'b1);
    iReset = 1'b1;
    #1;
    check("mid_rst_write", avm_write, 1'b0);
    check("mid_rst_busy", oBusy, 1'b0);
    check("mid_rst_pop", FF_readrequest, 1'b0);
    check("mid_rst_done", oDone, 1'b0);
    @(negedge iClk);
    check("mid_rst_addr", avm_address, 32'h0);
    check("mid_rst_busy2", oBusy, 1'b0);
    iReset = 1'b0;
    run_xfer(32'h6000, 32'd12, 3, 0, 0, -1, 0, 0, wc);
    check("post_rst_cycles", wc, 32'd3);

    // Randomized transfers.
    for (int t = 0; t < 16; t++) begin
      run_xfer($urandom, $urandom_range(0, 48), $urandom_range(0, 12),
               $urandom_range(1, 4), 30, -1, 0, 0, wc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
